// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared widths and encodings for the fetch stage of the 4-thread barrel
// pipeline. The imem address is {thread_id, pc}, so every thread owns a
// private 128-word slice of instruction memory.
// ----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int INSTR_W     = 32;
    localparam int TID_W       = 2;
    localparam int PC_W        = 7;
    localparam int ADDR_W      = TID_W + PC_W;
    localparam int NUM_THREADS = 1 << TID_W;

    // Encoding placed on id_instr whenever the IF/ID slot is empty.
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // An EX redirect kills a pipeline slot only if the slot is live and
    // belongs to the redirected thread.
    function automatic logic kill_match(
        input logic             br_taken,
        input logic             slot_valid,
        input logic [TID_W-1:0] br_tid,
        input logic [TID_W-1:0] slot_tid
    );
        return br_taken & slot_valid & (br_tid == slot_tid);
    endfunction

endpackage

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Fetch stage sitting directly after the per-thread PC generator. Each
// advancing cycle the incoming {thread_id, pc} goes to a synchronous imem
// (1-cycle read latency) and into the F register; on the following advancing
// edge the returned word is paired with that F entry and registered into
// the IF/ID pipeline register.
//
// Stalls: imem is not enabled while stalled, so its output may wander. The
// word belonging to the F entry is captured into a hold register on the
// first stall edge and used instead of imem_rdata when the pipe resumes.
//
// Redirects: an EX branch kills F and ID entries of the same thread. The new
// PC is produced upstream; this stage only discards stale work.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   pc_reset_pulse       synchronous flush, identical effect to reset
//   advance              pipeline advance enable (shared with PC gen)
//   pc_target, thread_id fetch request, meaningful when advance=1
//   ex_branch_taken,
//   ex_thread_id         EX redirect strobe and the thread it targets
//   imem_addr, imem_en   imem request (combinational)
//   imem_rdata           imem data for the request of the previous edge
//   id_instr, id_pc,
//   id_thread_id,
//   id_valid             IF/ID pipeline register outputs
// ----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_reset_pulse,
    input  logic               advance,
    input  logic [ADDR_W-1:0]  pc_target,
    input  logic [TID_W-1:0]   thread_id,
    input  logic               ex_branch_taken,
    input  logic [TID_W-1:0]   ex_thread_id,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [TID_W-1:0]   id_thread_id,
    output logic               id_valid
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               f_valid_q,    f_valid_d;
    logic [ADDR_W-1:0]  f_pc_q,       f_pc_d;
    logic [TID_W-1:0]   f_tid_q,      f_tid_d;

    logic               hold_valid_q, hold_valid_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

    logic               id_valid_q,   id_valid_d;
    logic [INSTR_W-1:0] id_instr_q,   id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q,      id_pc_d;
    logic [TID_W-1:0]   id_tid_q,     id_tid_d;

    logic               flush;
    logic               sq_f;
    logic               sq_id;
    logic               f_live;
    logic [INSTR_W-1:0] src_instr;

    // ------------------------------------------------------------------
    // Combinational request side
    // ------------------------------------------------------------------
    assign flush     = reset | pc_reset_pulse;
    assign imem_addr = pc_target;
    assign imem_en   = advance & ~reset & ~pc_reset_pulse;

    assign sq_f  = kill_match(ex_branch_taken, f_valid_q,  ex_thread_id, f_tid_q);
    assign sq_id = kill_match(ex_branch_taken, id_valid_q, ex_thread_id, id_tid_q);

    // After a stall the memory output is no longer trustworthy; the captured
    // copy takes over until the next advancing edge consumes it.
    assign src_instr = hold_valid_q ? hold_instr_q : imem_rdata;

    // F entry survives into ID only if it was live and not just redirected.
    assign f_live = f_valid_q & ~sq_f;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        f_valid_d    = f_valid_q;
        f_pc_d       = f_pc_q;
        f_tid_d      = f_tid_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_tid_d     = id_tid_q;

        if (advance) begin
            // New fetch always loads; a squash only affects the old F entry.
            f_valid_d    = 1'b1;
            f_pc_d       = pc_target;
            f_tid_d      = thread_id;

            id_valid_d   = f_live;
            id_instr_d   = f_live ? src_instr : NOP;
            id_pc_d      = f_pc_q;
            id_tid_d     = f_tid_q;

            hold_valid_d = 1'b0;
        end else begin
            // Capture happens on the first stall edge only; the data on
            // imem_rdata then still belongs to the F entry. A simultaneous
            // squash of F does not prevent the capture -- the F entry is
            // dead anyway and hold_valid is cleared on the next advance.
            if (!hold_valid_q && f_valid_q) begin
                hold_valid_d = 1'b1;
                hold_instr_d = imem_rdata;
            end

            if (sq_f) begin
                f_valid_d = 1'b0;
            end

            if (sq_id) begin
                id_valid_d = 1'b0;
                id_instr_d = NOP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (flush) begin
            f_valid_q    <= 1'b0;
            f_pc_q       <= '0;
            f_tid_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP;
            id_pc_q      <= '0;
            id_tid_q     <= '0;
        end else begin
            f_valid_q    <= f_valid_d;
            f_pc_q       <= f_pc_d;
            f_tid_q      <= f_tid_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_tid_q     <= id_tid_d;
        end
    end

    assign id_valid     = id_valid_q;
    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_thread_id = id_tid_q;

    // Decode relies on an empty slot carrying the NOP encoding.
    a_nop_when_invalid: assert property (
        @(posedge clk) !id_valid_q |-> (id_instr_q == NOP)
    );

endmodule
